atm_session_ctrl: RTL and testbench
===================================

// Module: atm_session_ctrl
// PURPOSE
//  Session sequencer in front of the account Authenticator. Latches the card's account number
//  and assembles a 4-digit decimal PIN from keypad digits. Presents both to the combinational
//  Authenticator and samples its found/auth result. Enforces the retry limit, keeps a
//  per-account lockout table and an inactivity timeout, and grants the session to downstream
//  transaction logic.
// PARAMETERS
//  MAX_ATTEMPTS    3     wrong-PIN tries before the account is locked
//  TIMEOUT_CYCLES  1000  idle clocks in PIN_ENTRY/ACTIVE before forced eject
//  PIN_DIGITS      4     digits required before enter is accepted
// PORTS
//  clk            in   1   system clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  card_in        in   1   level, card present
//  card_acc_num   in   4   account number read from card, valid while card_in=1
//  digit_valid    in   1   one-cycle strobe, keypad digit present
//  digit          in   4   keypad digit; values >9 ignored
//  enter          in   1   one-cycle strobe
//  cancel         in   1   one-cycle strobe
//  end_session    in   1   one-cycle strobe from transaction logic
//  auth_found     in   1   Authenticator acc_found_stat
//  auth_ok        in   1   Authenticator acc_auth_stat
//  auth_index     in   4   Authenticator acc_index_out
//  auth_acc_num   out  4   account number driven to Authenticator
//  auth_pin       out  16  binary PIN value driven to Authenticator (e.g. digits 1,2,3,4 -> 1234)
//  session_active out  1   high only in ACTIVE
//  acc_index      out  4   latched auth_index, valid while session_active
//  eject_card     out  1   one-cycle pulse on entry to EJECT
//  attempts_left  out  2   remaining tries
//  digit_count    out  3   digits entered so far
//  err_code       out  3   ERR_NONE/NOT_FOUND/BAD_PIN/LOCKED/TIMEOUT/CANCEL; held until next card
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, lock table cleared. Lock table is cleared only by reset.
//  States: IDLE, LOOKUP, PIN_ENTRY, CHECK, ACTIVE, EJECT.
//  IDLE: card_in rising edge -> latch card_acc_num to auth_acc_num, clear err_code -> LOOKUP.
//  LOOKUP (1 cycle): sample auth_found.
//   - !found -> err NOT_FOUND, EJECT.
//   - lock[acc] set -> err LOCKED, EJECT.
//   - otherwise attempts_left=MAX_ATTEMPTS, pin=0, digit_count=0 -> PIN_ENTRY.
//  PIN_ENTRY:
//   - Digit <=9 with digit_count<PIN_DIGITS -> pin=pin*10+digit (shift-add: (p<<3)+(p<<1)), count+1.
//   - Extra digits are ignored.
//   - enter with count==PIN_DIGITS -> CHECK; enter with fewer digits is ignored.
//  CHECK (1 cycle, auth_pin stable since previous edge): sample auth_ok.
//   - ok -> latch acc_index, err NONE -> ACTIVE.
//   - fail -> attempts_left-1, err BAD_PIN, pin/count cleared.
//   - If decremented value is 0: set lock[acc], err LOCKED -> EJECT; else -> PIN_ENTRY.
//  ACTIVE: end_session -> EJECT.
//  EJECT: eject_card pulses on the entry cycle only; pin cleared. Stays in EJECT until card_in=0 -> IDLE.
//  Timeout: counter cleared on state entry and on any digit_valid/enter/cancel.
//   - Reaching TIMEOUT_CYCLES-1 in PIN_ENTRY/ACTIVE -> err TIMEOUT, EJECT.
//  Priority, high to low: card_in falling (any state except IDLE) -> IDLE, clearing pin,
//   count and session with no eject pulse; cancel (-> err CANCEL, EJECT); enter; digit_valid.
//   Enter and digit in the same cycle: the digit is dropped.
//  auth_pin is zero-extended from a 14-bit accumulator; it is 0 outside PIN_ENTRY/CHECK.
//  Async reset mid-session returns to IDLE immediately. A card still present after reset
//   needs a fresh rising edge to start a session.
// STRUCTURE
//  Shared definitions header: state encodings, ERR_* codes, ACCOUNT_FOUND/AUTHENTICATED
//   constants (already shared with Authenticator).
//  Sub-module pin_accumulator: digit filter, multiply-add, digit_count, clear input.
//  FSM, timeout counter and 16-bit lock table stay in this module.
// TESTING
//  Card acc 1, digits 1,2,3,4, enter -> auth_pin=1234; CHECK, then session_active=1, acc_index=0.
//  Card acc 12 (auth_found=0) -> err NOT_FOUND, single eject_card pulse; remove card -> IDLE.
//  Card acc 2 wrong PIN 1111 x3 -> attempts 2,1 then LOCKED+eject; reinsert acc 2 -> LOCKED at LOOKUP.
//  Digits 5,6 then enter -> ignored, state PIN_ENTRY; digit 12 ignored; fifth digit ignored.
//  PIN_ENTRY idle TIMEOUT_CYCLES clocks -> err TIMEOUT, eject; card pulled mid-PIN -> IDLE, no eject.
//  rst_n low during ACTIVE -> all outputs 0 asynchronously, lock table cleared.

Source files
------------

// File: rtl/atm_session_ctrl_pkg.sv
// Shared definitions for the ATM session sequencer: state and error encodings,
// Authenticator status constants and the PIN multiply-add helper.
package atm_session_ctrl_pkg;

    localparam int DEF_MAX_ATTEMPTS   = 3;
    localparam int DEF_TIMEOUT_CYCLES = 1000;
    localparam int DEF_PIN_DIGITS     = 4;
    localparam int PIN_ACC_W          = 14;

    localparam logic ACCOUNT_FOUND = 1'b1;
    localparam logic AUTHENTICATED = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_PIN_ENTRY = 3'd2,
        ST_CHECK     = 3'd3,
        ST_ACTIVE    = 3'd4,
        ST_EJECT     = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_NOT_FOUND = 3'd1,
        ERR_BAD_PIN   = 3'd2,
        ERR_LOCKED    = 3'd3,
        ERR_TIMEOUT   = 3'd4,
        ERR_CANCEL    = 3'd5
    } err_t;

    // p*10 + d built from shifts so no multiplier is inferred
    function automatic logic [PIN_ACC_W-1:0] pin_mac(input logic [PIN_ACC_W-1:0] p,
                                                     input logic [3:0] d);
        return (p << 3) + (p << 1) + {{(PIN_ACC_W-4){1'b0}}, d};
    endfunction

endpackage

// File: rtl/atm_session_ctrl_pin_accumulator.sv
// Keypad PIN accumulator: drops non-decimal and surplus digits, builds the
// binary PIN value and counts accepted digits.
module pin_accumulator
    import atm_session_ctrl_pkg::*;
#(
    parameter int PIN_DIGITS = DEF_PIN_DIGITS
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 digit_valid,
    input  logic [3:0]           digit,
    output logic [PIN_ACC_W-1:0] pin,
    output logic [2:0]           digit_count
);

    localparam logic [2:0] DIGITS_MAX = 3'(PIN_DIGITS);

    logic [PIN_ACC_W-1:0] pin_q, pin_d;
    logic [2:0]           count_q, count_d;

    always_comb begin
        pin_d   = pin_q;
        count_d = count_q;
        if (clear) begin
            pin_d   = '0;
            count_d = '0;
        end else if (digit_valid && (digit <= 4'd9) && (count_q < DIGITS_MAX)) begin
            pin_d   = pin_mac(pin_q, digit);
            count_d = count_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_q   <= '0;
            count_q <= '0;
        end else begin
            pin_q   <= pin_d;
            count_q <= count_d;
        end
    end

    assign pin         = pin_q;
    assign digit_count = count_q;

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: card latch, PIN collection, retry limit with a per-account
// lockout table, inactivity timeout and session grant to transaction logic.
module atm_session_ctrl
    import atm_session_ctrl_pkg::*;
#(
    parameter int MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int PIN_DIGITS     = DEF_PIN_DIGITS
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        card_in,
    input  logic [3:0]  card_acc_num,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        enter,
    input  logic        cancel,
    input  logic        end_session,
    input  logic        auth_found,
    input  logic        auth_ok,
    input  logic [3:0]  auth_index,
    output logic [3:0]  auth_acc_num,
    output logic [15:0] auth_pin,
    output logic        session_active,
    output logic [3:0]  acc_index,
    output logic        eject_card,
    output logic [1:0]  attempts_left,
    output logic [2:0]  digit_count,
    output logic [2:0]  err_code
);

    localparam int               TIMER_W       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       ATTEMPTS_INIT = 2'(MAX_ATTEMPTS);
    localparam logic [2:0]       DIGITS_REQ    = 3'(PIN_DIGITS);

    state_t               state_q, state_d;
    err_t                 err_q, err_d;
    logic [3:0]           acc_num_q, acc_num_d;
    logic [3:0]           acc_index_q, acc_index_d;
    logic [1:0]           attempts_q, attempts_d;
    logic [15:0]          lock_q, lock_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 card_q, card_d;
    logic                 eject_q, eject_d;

    logic                 pin_clear, pin_digit_valid, activity, timed_out;
    logic [PIN_ACC_W-1:0] pin_value;
    logic [2:0]           pin_count;

    pin_accumulator #(.PIN_DIGITS(PIN_DIGITS)) u_pin_acc (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (pin_clear),
        .digit_valid (pin_digit_valid),
        .digit       (digit),
        .pin         (pin_value),
        .digit_count (pin_count)
    );

    assign activity  = digit_valid | enter | cancel;
    assign timed_out = !activity && (timer_q == TIMER_LAST);

    always_comb begin
        state_d         = state_q;
        err_d           = err_q;
        acc_num_d       = acc_num_q;
        acc_index_d     = acc_index_q;
        attempts_d      = attempts_q;
        lock_d          = lock_q;
        card_d          = card_in;
        pin_clear       = 1'b0;
        pin_digit_valid = 1'b0;

        if (state_q != ST_IDLE && !card_in) begin
            state_d   = ST_IDLE;
            pin_clear = 1'b1;
        end else if (cancel && state_q != ST_IDLE && state_q != ST_EJECT) begin
            err_d   = ERR_CANCEL;
            state_d = ST_EJECT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (card_in && !card_q) begin
                        acc_num_d = card_acc_num;
                        err_d     = ERR_NONE;
                        state_d   = ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (auth_found != ACCOUNT_FOUND) begin
                        err_d   = ERR_NOT_FOUND;
                        state_d = ST_EJECT;
                    end else if (lock_q[acc_num_q]) begin
                        err_d   = ERR_LOCKED;
                        state_d = ST_EJECT;
                    end else begin
                        attempts_d = ATTEMPTS_INIT;
                        pin_clear  = 1'b1;
                        state_d    = ST_PIN_ENTRY;
                    end
                end
                ST_PIN_ENTRY: begin
                    // enter outranks a same-cycle digit, which is then dropped
                    if (enter) begin
                        if (pin_count == DIGITS_REQ) state_d = ST_CHECK;
                    end else if (digit_valid) begin
                        pin_digit_valid = 1'b1;
                    end else if (timed_out) begin
                        err_d   = ERR_TIMEOUT;
                        state_d = ST_EJECT;
                    end
                end
                ST_CHECK: begin
                    if (auth_ok == AUTHENTICATED) begin
                        acc_index_d = auth_index;
                        err_d       = ERR_NONE;
                        state_d     = ST_ACTIVE;
                    end else begin
                        attempts_d = attempts_q - 2'd1;
                        pin_clear  = 1'b1;
                        if (attempts_q == 2'd1) begin
                            lock_d[acc_num_q] = 1'b1;
                            err_d             = ERR_LOCKED;
                            state_d           = ST_EJECT;
                        end else begin
                            err_d   = ERR_BAD_PIN;
                            state_d = ST_PIN_ENTRY;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (end_session) begin
                        state_d = ST_EJECT;
                    end else if (timed_out) begin
                        err_d   = ERR_TIMEOUT;
                        state_d = ST_EJECT;
                    end
                end
                default: ;
            endcase
        end

        eject_d = (state_d == ST_EJECT) && (state_q != ST_EJECT);
        if (eject_d) pin_clear = 1'b1;

        if (state_d != state_q || activity) begin
            timer_d = '0;
        end else if (state_q == ST_PIN_ENTRY || state_q == ST_ACTIVE) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = '0;
        end
    end

    // card_q resets high so a card left in the slot across reset needs a fresh insertion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            err_q       <= ERR_NONE;
            acc_num_q   <= '0;
            acc_index_q <= '0;
            attempts_q  <= '0;
            lock_q      <= '0;
            timer_q     <= '0;
            card_q      <= 1'b1;
            eject_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            acc_num_q   <= acc_num_d;
            acc_index_q <= acc_index_d;
            attempts_q  <= attempts_d;
            lock_q      <= lock_d;
            timer_q     <= timer_d;
            card_q      <= card_d;
            eject_q     <= eject_d;
        end
    end

    assign auth_acc_num   = acc_num_q;
    assign auth_pin       = (state_q == ST_PIN_ENTRY || state_q == ST_CHECK)
                            ? {{(16-PIN_ACC_W){1'b0}}, pin_value} : 16'd0;
    assign session_active = (state_q == ST_ACTIVE);
    assign acc_index      = acc_index_q;
    assign eject_card     = eject_q;
    assign attempts_left  = attempts_q;
    assign digit_count    = pin_count;
    assign err_code       = err_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Scoreboard bench for atm_session_ctrl with a behavioural Authenticator
// (accounts 1..11 exist, index = account-1, account 1 PIN 1234, others 1000+account).
module tb_atm_session_ctrl;

    localparam int E_NONE = 0, E_NOT_FOUND = 1, E_BAD_PIN = 2, E_LOCKED = 3,
                   E_TIMEOUT = 4, E_CANCEL = 5;
    localparam int TIMEOUT = 1000;

    logic        clk, rst_n, card_in, digitValid, enter, cancel, endSession;
    logic [3:0]  cardAccNum, digit;
    logic        authFound, authOk;
    logic [3:0]  authIndex, authAccNum, accIndex;
    logic [15:0] authPin;
    logic        sessionActive, ejectCard;
    logic [1:0]  attemptsLeft;
    logic [2:0]  digitCount, errCode;

    typedef enum {F_ACC, F_PIN, F_ACTIVE, F_INDEX, F_EJECT, F_ATT, F_CNT, F_ERR} field_t;
    typedef struct {
        string       tag;
        field_t      field;
        logic [15:0] value;
    } expect_t;

    expect_t scoreboard[$];
    int      totalChecks = 0;
    int      badChecks   = 0;

    atm_session_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .card_in        (card_in),
        .card_acc_num   (cardAccNum),
        .digit_valid    (digitValid),
        .digit          (digit),
        .enter          (enter),
        .cancel         (cancel),
        .end_session    (endSession),
        .auth_found     (authFound),
        .auth_ok        (authOk),
        .auth_index     (authIndex),
        .auth_acc_num   (authAccNum),
        .auth_pin       (authPin),
        .session_active (sessionActive),
        .acc_index      (accIndex),
        .eject_card     (ejectCard),
        .attempts_left  (attemptsLeft),
        .digit_count    (digitCount),
        .err_code       (errCode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] goodPin(input logic [3:0] acc);
        return (acc == 4'd1) ? 16'd1234 : 16'd1000 + {12'd0, acc};
    endfunction

    // behavioural Authenticator
    always_comb begin
        authFound = (authAccNum != 4'd0) && (authAccNum < 4'd12);
        authIndex = authAccNum - 4'd1;
        authOk    = authFound && (authPin == goodPin(authAccNum));
    end

    function automatic logic [15:0] observe(input field_t f);
        case (f)
            F_ACC:    return {12'd0, authAccNum};
            F_PIN:    return authPin;
            F_ACTIVE: return {15'd0, sessionActive};
            F_INDEX:  return {12'd0, accIndex};
            F_EJECT:  return {15'd0, ejectCard};
            F_ATT:    return {14'd0, attemptsLeft};
            F_CNT:    return {13'd0, digitCount};
            default:  return {13'd0, errCode};
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] want);
        totalChecks++;
        if (got !== want) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic expectOut(input string tag, input field_t f, input int v);
        expect_t e;
        e.tag   = tag;
        e.field = f;
        e.value = 16'(v);
        scoreboard.push_back(e);
    endtask

    task automatic drainScoreboard();
        expect_t e;
        while (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            checkOutput(e.tag, observe(e.field), e.value);
        end
    endtask

    // one clock with the currently driven inputs; strobes drop, then pending expectations are checked
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        digitValid = 1'b0;
        enter      = 1'b0;
        cancel     = 1'b0;
        endSession = 1'b0;
        drainScoreboard();
    endtask

    task automatic pressDigit(input logic [3:0] d);
        digitValid = 1'b1;
        digit      = d;
        applyStimulus();
    endtask

    task automatic pressEnter();
        enter = 1'b1;
        applyStimulus();
    endtask

    // insert card and step through LOOKUP; caller pushes expectations for the LOOKUP outcome
    task automatic insertCard(input logic [3:0] acc);
        card_in    = 1'b1;
        cardAccNum = acc;
        expectOut("latch_acc", F_ACC, int'(acc));
        applyStimulus();
    endtask

    task automatic removeCard();
        card_in = 1'b0;
        expectOut("removed_active", F_ACTIVE, 0);
        expectOut("removed_eject", F_EJECT, 0);
        applyStimulus();
    endtask

    task automatic enterPin(input int d0, input int d1, input int d2, input int d3);
        int model;
        int ds[4];
        model = 0;
        ds = '{d0, d1, d2, d3};
        for (int i = 0; i < 4; i++) begin
            model = model * 10 + ds[i];
            expectOut("pin_acc", F_PIN, model);
            expectOut("pin_cnt", F_CNT, i + 1);
            pressDigit(4'(ds[i]));
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; card_in = 1'b0; cardAccNum = '0; digitValid = 1'b0; digit = '0;
        enter = 1'b0; cancel = 1'b0; endSession = 1'b0;
        #12;
        expectOut("rst_active", F_ACTIVE, 0);
        expectOut("rst_eject", F_EJECT, 0);
        expectOut("rst_err", F_ERR, 0);
        expectOut("rst_att", F_ATT, 0);
        expectOut("rst_pin", F_PIN, 0);
        expectOut("rst_acc", F_ACC, 0);
        drainScoreboard();
        rst_n = 1'b1;
        applyStimulus();
        applyStimulus();

        // good session, account 1
        insertCard(4'd1);
        expectOut("lookup_att", F_ATT, 3);
        expectOut("lookup_cnt", F_CNT, 0);
        expectOut("lookup_err", F_ERR, E_NONE);
        applyStimulus();
        enterPin(1, 2, 3, 4);
        expectOut("check_pin", F_PIN, 1234);
        expectOut("check_active", F_ACTIVE, 0);
        pressEnter();
        expectOut("grant_active", F_ACTIVE, 1);
        expectOut("grant_index", F_INDEX, 0);
        expectOut("grant_err", F_ERR, E_NONE);
        expectOut("grant_pin_masked", F_PIN, 0);
        applyStimulus();
        endSession = 1'b1;
        expectOut("end_eject", F_EJECT, 1);
        expectOut("end_active", F_ACTIVE, 0);
        applyStimulus();
        expectOut("end_eject_once", F_EJECT, 0);
        applyStimulus();
        removeCard();

        // unknown account
        insertCard(4'd12);
        expectOut("nf_err", F_ERR, E_NOT_FOUND);
        expectOut("nf_eject", F_EJECT, 1);
        applyStimulus();
        expectOut("nf_eject_once", F_EJECT, 0);
        applyStimulus();
        removeCard();

        // three wrong PINs lock account 2
        insertCard(4'd2);
        applyStimulus();
        for (int t = 0; t < 3; t++) begin
            enterPin(1, 1, 1, 1);
            pressEnter();
            expectOut("bad_att", F_ATT, 2 - t);
            if (t < 2) begin
                expectOut("bad_err", F_ERR, E_BAD_PIN);
                expectOut("bad_cnt", F_CNT, 0);
                expectOut("bad_eject", F_EJECT, 0);
            end else begin
                expectOut("lock_err", F_ERR, E_LOCKED);
                expectOut("lock_eject", F_EJECT, 1);
            end
            applyStimulus();
        end
        removeCard();
        insertCard(4'd2);
        expectOut("relock_err", F_ERR, E_LOCKED);
        expectOut("relock_eject", F_EJECT, 1);
        applyStimulus();
        removeCard();

        // short enter, out-of-range and surplus digits, then idle timeout
        insertCard(4'd1);
        applyStimulus();
        pressDigit(4'd5);
        pressDigit(4'd6);
        expectOut("short_enter_cnt", F_CNT, 2);
        expectOut("short_enter_pin", F_PIN, 56);
        pressEnter();
        expectOut("digit12_cnt", F_CNT, 2);
        pressDigit(4'd12);
        expectOut("still_entry_cnt", F_CNT, 3);
        expectOut("still_entry_pin", F_PIN, 567);
        pressDigit(4'd7);
        pressDigit(4'd8);
        expectOut("fifth_cnt", F_CNT, 4);
        expectOut("fifth_pin", F_PIN, 5678);
        pressDigit(4'd9);
        digitValid = 1'b1; digit = 4'd3; enter = 1'b1;
        expectOut("enter_drops_digit", F_PIN, 5678);
        applyStimulus();
        expectOut("wrong_err", F_ERR, E_BAD_PIN);
        expectOut("wrong_att", F_ATT, 2);
        applyStimulus();
        repeat (TIMEOUT - 2) applyStimulus();
        expectOut("pre_timeout_eject", F_EJECT, 0);
        expectOut("pre_timeout_err", F_ERR, E_BAD_PIN);
        applyStimulus();
        expectOut("timeout_err", F_ERR, E_TIMEOUT);
        expectOut("timeout_eject", F_EJECT, 1);
        applyStimulus();
        removeCard();

        // card pulled mid-PIN
        insertCard(4'd1);
        applyStimulus();
        pressDigit(4'd1);
        pressDigit(4'd2);
        expectOut("pull_cnt", F_CNT, 0);
        expectOut("pull_pin", F_PIN, 0);
        removeCard();
        expectOut("pull_no_eject", F_EJECT, 0);
        applyStimulus();

        // cancel during PIN entry
        insertCard(4'd3);
        applyStimulus();
        cancel = 1'b1;
        expectOut("cancel_err", F_ERR, E_CANCEL);
        expectOut("cancel_eject", F_EJECT, 1);
        applyStimulus();
        removeCard();

        // async reset while ACTIVE, card left in
        insertCard(4'd1);
        applyStimulus();
        enterPin(1, 2, 3, 4);
        pressEnter();
        expectOut("pre_rst_active", F_ACTIVE, 1);
        applyStimulus();
        #2;
        rst_n = 1'b0;
        #1;
        expectOut("arst_active", F_ACTIVE, 0);
        expectOut("arst_acc", F_ACC, 0);
        expectOut("arst_index", F_INDEX, 0);
        expectOut("arst_att", F_ATT, 0);
        expectOut("arst_cnt", F_CNT, 0);
        drainScoreboard();
        applyStimulus();
        rst_n = 1'b1;
        applyStimulus();
        expectOut("no_fresh_edge_acc", F_ACC, 0);
        expectOut("no_fresh_edge_att", F_ATT, 0);
        applyStimulus();
        removeCard();

        // lock table cleared by reset: account 2 usable again
        insertCard(4'd2);
        expectOut("unlocked_att", F_ATT, 3);
        expectOut("unlocked_err", F_ERR, E_NONE);
        expectOut("unlocked_eject", F_EJECT, 0);
        applyStimulus();
        removeCard();

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
